// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter that merges the core's instruction-fetch and data channels
// onto one single-port memory: one transaction in flight, all outputs registered.
module imem_dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_ack_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
  typedef enum logic {CH_IMEM = 1'b0, CH_DMEM = 1'b1} chan_t;

  state_t                r_state;
  chan_t                 r_last_grant;
  chan_t                 r_winner;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_imem_rdata;
  logic [DATA_WIDTH-1:0] r_dmem_rdata;
  logic                  r_imem_ack;
  logic                  r_dmem_ack;

  logic                  w_any_req;
  chan_t                 w_pick;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_any_req = imem_req_i | dmem_req_i;
    w_pick    = CH_IMEM;
    if (dmem_req_i && (!imem_req_i || r_last_grant == CH_IMEM)) begin
      w_pick = CH_DMEM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state      <= ST_IDLE;
      r_last_grant <= CH_DMEM;
      r_winner     <= CH_IMEM;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
      r_imem_ack   <= 1'b0;
      r_dmem_ack   <= 1'b0;
    end else begin
      r_imem_ack <= 1'b0;
      r_dmem_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_winner     <= w_pick;
            r_last_grant <= w_pick;
            r_mem_req    <= 1'b1;
            if (w_pick == CH_DMEM) begin
              r_mem_we    <= dmem_we_i;
              r_mem_addr  <= dmem_addr_i;
              r_mem_wdata <= dmem_wdata_i;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= imem_addr_i;
              r_mem_wdata <= '0;
            end
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            // Writes complete without disturbing the requester's last read data.
            if (r_winner == CH_DMEM) begin
              r_dmem_ack <= 1'b1;
              if (!r_mem_we) r_dmem_rdata <= mem_rdata_i;
            end else begin
              r_imem_ack <= 1'b1;
              if (!r_mem_we) r_imem_rdata <= mem_rdata_i;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_rdata_o = r_imem_rdata;
  assign imem_ack_o   = r_imem_ack;
  assign dmem_rdata_o = r_dmem_rdata;
  assign dmem_ack_o   = r_dmem_ack;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level timing/round-robin model.
module tb_imem_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          imem_req_i;
  logic [AW-1:0] imem_addr_i;
  logic [DW-1:0] imem_rdata_o;
  logic          imem_ack_o;
  logic          dmem_req_i;
  logic          dmem_we_i;
  logic [AW-1:0] dmem_addr_i;
  logic [DW-1:0] dmem_wdata_i;
  logic [DW-1:0] dmem_rdata_o;
  logic          dmem_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  always #5 clk_i = ~clk_i;

  imem_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .imem_req_i  (imem_req_i),
    .imem_addr_i (imem_addr_i),
    .imem_rdata_o(imem_rdata_o),
    .imem_ack_o  (imem_ack_o),
    .dmem_req_i  (dmem_req_i),
    .dmem_we_i   (dmem_we_i),
    .dmem_addr_i (dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_rdata_o(dmem_rdata_o),
    .dmem_ack_o  (dmem_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: one transaction = grant cycle g, memory busy g+1..g+1+w, ack g+2+w, free at g+3+w.
  int          req_lo, req_hi, ack_cyc, next_idle;
  bit          last_d, win_d, win_we, gnt_i, gnt_d;
  logic [31:0] win_addr, win_wdata, pend_rd, exp_irdata, exp_drdata;
  int          wait_sel, spur_mode;
  bit          rand_wait, rel_i, rel_d;
  logic [31:0] mem_arr [16];
  int          ack_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    req_lo     = -1;
    req_hi     = -2;
    ack_cyc    = -1;
    next_idle  = cyc;
    last_d     = 1'b1;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    exp_irdata = '0;
    exp_drdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},    32'(mem_req_o),  32'h0);
    check({tag, "_mem_we"},     32'(mem_we_o),   32'h0);
    check({tag, "_mem_addr"},   mem_addr_o,      32'h0);
    check({tag, "_mem_wdata"},  mem_wdata_o,     32'h0);
    check({tag, "_imem_ack"},   32'(imem_ack_o), 32'h0);
    check({tag, "_dmem_ack"},   32'(dmem_ack_o), 32'h0);
    check({tag, "_imem_rdata"}, imem_rdata_o,    32'h0);
    check({tag, "_dmem_rdata"}, dmem_rdata_o,    32'h0);
  endtask

  // Called just after an active edge; asserts reset, checks outputs, releases before the next edge.
  task automatic do_reset();
    arst_ni   = 1'b0;
    mem_ack_i = 1'b0;
    #2;
    check_all_zero("rst");
    arst_ni = 1'b1;
    model_reset();
  endtask

  // Evaluates one clock cycle: memory responder, output checks, requester release, grant prediction.
  task automatic cycle();
    bit in_win, e_ia, e_da;
    int idx, w;
    in_win = (cyc >= req_lo) && (cyc <= req_hi);
    if (cyc == req_hi) begin
      idx       = int'(win_addr[5:2]);
      mem_ack_i = 1'b1;
      if (win_we) begin
        mem_arr[idx] = win_wdata;
        mem_rdata_i  = $urandom;
      end else begin
        pend_rd     = mem_arr[idx];
        mem_rdata_i = pend_rd;
      end
    end else if (in_win) begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
    end else begin
      mem_ack_i   = (spur_mode == 1) || (spur_mode == 2 && $urandom_range(0, 1) == 1);
      mem_rdata_i = 32'hBADBAD00;
    end

    e_ia = (cyc == ack_cyc) && !win_d;
    e_da = (cyc == ack_cyc) && win_d;
    if (cyc == ack_cyc && !win_we) begin
      if (win_d) exp_drdata = pend_rd;
      else       exp_irdata = pend_rd;
    end

    check("mem_req", 32'(mem_req_o), 32'(in_win));
    if (in_win) begin
      check("mem_we",   32'(mem_we_o), 32'(win_we));
      check("mem_addr", mem_addr_o,    win_addr);
      if (win_we) check("mem_wdata", mem_wdata_o, win_wdata);
    end
    check("imem_ack",   32'(imem_ack_o), 32'(e_ia));
    check("dmem_ack",   32'(dmem_ack_o), 32'(e_da));
    check("imem_rdata", imem_rdata_o,    exp_irdata);
    check("dmem_rdata", dmem_rdata_o,    exp_drdata);
    if (imem_ack_o) ack_log.push_back(0);
    if (dmem_ack_o) ack_log.push_back(1);

    if (e_ia) begin gnt_i = 1'b0; if (rel_i) imem_req_i = 1'b0; end
    if (e_da) begin gnt_d = 1'b0; if (rel_d) dmem_req_i = 1'b0; end

    if (cyc >= next_idle && (imem_req_i || dmem_req_i)) begin
      win_d     = dmem_req_i && (!imem_req_i || !last_d);
      last_d    = win_d;
      win_we    = win_d && dmem_we_i;
      win_addr  = win_d ? dmem_addr_i : imem_addr_i;
      win_wdata = dmem_wdata_i;
      if (win_d) gnt_d = 1'b1; else gnt_i = 1'b1;
      w         = rand_wait ? int'($urandom_range(0, 4)) : wait_sel;
      req_lo    = cyc + 1;
      req_hi    = cyc + 1 + w;
      ack_cyc   = cyc + 2 + w;
      next_idle = cyc + 3 + w;
    end

    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic check_log(input string tag, input int exp_q [$]);
    check({tag, "_count"}, 32'(ack_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, "_order"}, 32'((i < ack_log.size()) ? ack_log[i] : 9), 32'(exp_q[i]));
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((imem_req_i || dmem_req_i || cyc < next_idle) && guard < 100) begin
      cycle();
      guard++;
    end
    check("drain_bound", 32'(guard < 100), 32'h1);
  endtask

  initial begin
    arst_ni = 1'b0; imem_req_i = 1'b0; imem_addr_i = '0;
    dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    foreach (mem_arr[i]) mem_arr[i] = $urandom;
    mem_arr[0] = 32'hDEADBEEF;
    spur_mode = 0; rand_wait = 1'b0; wait_sel = 0; rel_i = 1'b1; rel_d = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("por");
    arst_ni = 1'b1;
    model_reset();

    // Single imem read, zero-wait memory.
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_1000; wait_sel = 0;
    repeat (4) cycle();
    check("t1_imem_rdata", imem_rdata_o, 32'hDEADBEEF);
    check_log("t1", '{0});

    // dmem write with three wait cycles.
    ack_log.delete();
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h0000_2004; dmem_wdata_i = 32'h1234_5678;
    wait_sel = 3;
    repeat (8) cycle();
    dmem_we_i = 1'b0;
    check("t2_dmem_rdata", dmem_rdata_o, 32'h0);
    check_log("t2", '{1});

    // Both requests held from reset release: strict alternation starting with IMEM.
    do_reset();
    ack_log.delete();
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_1004;
    dmem_req_i = 1'b1; dmem_addr_i = 32'h0000_2008;
    rel_i = 1'b0; rel_d = 1'b0; wait_sel = 0;
    repeat (12) cycle();
    check_log("t3", '{0, 1, 0, 1});
    imem_req_i = 1'b0; dmem_req_i = 1'b0;
    drain();

    // dmem streaming; imem raised mid-way wins the next tie.
    ack_log.delete();
    rel_i = 1'b1; rel_d = 1'b0;
    dmem_req_i = 1'b1; dmem_addr_i = 32'h0000_2010;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) begin imem_req_i = 1'b1; imem_addr_i = 32'h0000_1008; end
      cycle();
    end
    check_log("t4", '{1, 1, 0, 1});
    dmem_req_i = 1'b0; rel_d = 1'b1;
    drain();

    // Reset while BUSY abandons the access; IMEM wins the first tie afterwards.
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_100C; wait_sel = 20;
    repeat (3) cycle();
    do_reset();
    imem_req_i = 1'b0;
    ack_log.delete();
    repeat (6) cycle();
    check_log("t5_noack", '{});
    imem_req_i = 1'b1; dmem_req_i = 1'b1; dmem_addr_i = 32'h0000_2014; wait_sel = 0;
    drain();
    check_log("t5_prio", '{0, 1});

    // Spurious memory acks in IDLE and RESP are ignored.
    ack_log.delete();
    spur_mode = 1;
    mem_arr[3] = 32'hCAFE_F00D;
    repeat (3) cycle();
    dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 32'h0000_300C;
    repeat (6) cycle();
    check("t6_dmem_rdata", dmem_rdata_o, 32'hCAFE_F00D);
    check_log("t6", '{1});

    // Random traffic with random wait states and spurious acks.
    spur_mode = 2; rand_wait = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (!imem_req_i && $urandom_range(0, 2) == 0) begin
        imem_req_i = 1'b1; imem_addr_i = $urandom;
      end else if (imem_req_i && !gnt_i && $urandom_range(0, 7) == 0) begin
        imem_req_i = 1'b0;
      end
      if (!dmem_req_i && $urandom_range(0, 2) == 0) begin
        dmem_req_i = 1'b1; dmem_we_i = 1'($urandom_range(0, 1));
        dmem_addr_i = $urandom; dmem_wdata_i = $urandom;
      end else if (dmem_req_i && !gnt_d && $urandom_range(0, 7) == 0) begin
        dmem_req_i = 1'b0;
      end
      rel_i = ($urandom_range(0, 3) != 0);
      rel_d = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rel_i = 1'b1; rel_d = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
